// File: rtl/avalon_master_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_master_arbiter
//
// Shares one Avalon-MM master port between two requesters (0: pixel/fill write
// engine, 1: CSR read/write path). Arbitration is round-robin per transaction.
// A registered grant is held until the fabric accepts the command. Accepted
// reads push the issuing requester ID into a small in-order FIFO, so that each
// returning readdatavalid beat is steered to the requester that issued it.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   rN_address/writedata/write/read requester N command inputs
//   rN_waitrequest                  stall to requester N
//   rN_readdata/readdatavalid       read return to requester N (data broadcast)
//   master_*                        Avalon-MM master towards the fabric
//   pending_count                   reads issued but not yet returned
//   rsp_error                       sticky: read beat arrived with none pending
// -----------------------------------------------------------------------------
module avalon_master_arbiter #(
    parameter int ADDRESSWIDTH = 26,
    parameter int DATAWIDTH    = 32,
    parameter int MAX_PENDING  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADDRESSWIDTH-1:0]       r0_address,
    input  logic [ADDRESSWIDTH-1:0]       r1_address,
    input  logic [DATAWIDTH-1:0]          r0_writedata,
    input  logic [DATAWIDTH-1:0]          r1_writedata,
    input  logic                          r0_write,
    input  logic                          r1_write,
    input  logic                          r0_read,
    input  logic                          r1_read,
    output logic                          r0_waitrequest,
    output logic                          r1_waitrequest,
    output logic [DATAWIDTH-1:0]          r0_readdata,
    output logic [DATAWIDTH-1:0]          r1_readdata,
    output logic                          r0_readdatavalid,
    output logic                          r1_readdatavalid,
    output logic [ADDRESSWIDTH-1:0]       master_address,
    output logic [DATAWIDTH-1:0]          master_writedata,
    output logic                          master_write,
    output logic                          master_read,
    input  logic [DATAWIDTH-1:0]          master_readdata,
    input  logic                          master_readdatavalid,
    input  logic                          master_waitrequest,
    output logic [$clog2(MAX_PENDING):0]  pending_count,
    output logic                          rsp_error
);

    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    rr_r;
    logic                    rr_nxt_s;
    logic [MAX_PENDING-1:0]  fifo_r;
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [CW-1:0]           count_r;
    logic [CW-1:0]           count_nxt_s;
    logic                    rsp_error_r;

    logic                    granted_s;
    logic                    gnt_id_s;
    logic                    sel_write_s;
    logic                    sel_read_s;
    logic [ADDRESSWIDTH-1:0] sel_address_s;
    logic [DATAWIDTH-1:0]    sel_writedata_s;
    logic                    cmd_write_s;
    logic                    cmd_read_s;
    logic                    active_s;
    logic                    accept_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    gnt_wait_s;
    logic                    head_id_s;

    // A requester can be served when it writes, or reads with FIFO room left.
    function automatic logic eligible(input logic wr, input logic rd,
                                      input logic [CW-1:0] cnt);
        return wr | (rd & (cnt < MAX_CNT));
    endfunction

    // Command mux from the granted requester, handshake and FIFO push/pop.
    always_comb begin
        granted_s       = (state_r != IDLE);
        gnt_id_s        = (state_r == GRANT1);
        sel_write_s     = 1'b0;
        sel_read_s      = 1'b0;
        sel_address_s   = {ADDRESSWIDTH{1'b0}};
        sel_writedata_s = {DATAWIDTH{1'b0}};
        if (state_r == GRANT1) begin
            sel_write_s     = r1_write;
            sel_read_s      = r1_read;
            sel_address_s   = r1_address;
            sel_writedata_s = r1_writedata;
        end else if (state_r == GRANT0) begin
            sel_write_s     = r0_write;
            sel_read_s      = r0_read;
            sel_address_s   = r0_address;
            sel_writedata_s = r0_writedata;
        end else begin
            sel_write_s     = 1'b0;
            sel_read_s      = 1'b0;
        end
        // Write wins over a simultaneous read; a read never issues into a full FIFO.
        cmd_write_s      = sel_write_s;
        cmd_read_s       = sel_read_s & ~sel_write_s & (count_r < MAX_CNT);
        active_s         = cmd_write_s | cmd_read_s;
        master_write     = cmd_write_s;
        master_read      = cmd_read_s;
        master_address   = sel_address_s;
        master_writedata = sel_writedata_s;
        accept_s         = active_s & ~master_waitrequest;
        push_s           = accept_s & cmd_read_s;
        pop_s            = master_readdatavalid & (count_r != {CW{1'b0}});
        count_nxt_s      = count_r + CW'(push_s) - CW'(pop_s);
        if (sel_read_s & ~sel_write_s & (count_r >= MAX_CNT)) begin
            gnt_wait_s = 1'b1;
        end else begin
            gnt_wait_s = master_waitrequest;
        end
        r0_waitrequest = (state_r == GRANT0) ? gnt_wait_s : 1'b1;
        r1_waitrequest = (state_r == GRANT1) ? gnt_wait_s : 1'b1;
    end

    // Read return steering straight from the FIFO head.
    always_comb begin
        head_id_s        = fifo_r[rd_ptr_r];
        r0_readdatavalid = pop_s & ~head_id_s;
        r1_readdatavalid = pop_s & head_id_s;
        r0_readdata      = master_readdata;
        r1_readdata      = master_readdata;
        pending_count    = count_r;
        rsp_error        = rsp_error_r;
    end

    // Grant FSM next state; post-accept decisions use the count as it will be
    // next cycle so a back-to-back read can never overfill the FIFO.
    always_comb begin
        state_nxt_s = state_r;
        rr_nxt_s    = rr_r;
        case (state_r)
            IDLE: begin
                if (eligible(r0_write, r0_read, count_r) &&
                    eligible(r1_write, r1_read, count_r)) begin
                    state_nxt_s = rr_r ? GRANT1 : GRANT0;
                end else if (eligible(r0_write, r0_read, count_r)) begin
                    state_nxt_s = GRANT0;
                end else if (eligible(r1_write, r1_read, count_r)) begin
                    state_nxt_s = GRANT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT0: begin
                if (accept_s) begin
                    rr_nxt_s = 1'b1;
                    if (eligible(r1_write, r1_read, count_nxt_s)) begin
                        state_nxt_s = GRANT1;
                    end else if (eligible(r0_write, r0_read, count_nxt_s)) begin
                        state_nxt_s = GRANT0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (!active_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT0;
                end
            end
            GRANT1: begin
                if (accept_s) begin
                    rr_nxt_s = 1'b0;
                    if (eligible(r0_write, r0_read, count_nxt_s)) begin
                        state_nxt_s = GRANT0;
                    end else if (eligible(r1_write, r1_read, count_nxt_s)) begin
                        state_nxt_s = GRANT1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (!active_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                rr_nxt_s    = 1'b0;
            end
        endcase
    end

    // Grant state and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rr_r    <= rr_nxt_s;
        end
    end

    // Pending-read ID FIFO, occupancy counter and sticky response error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_r      <= {MAX_PENDING{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            rsp_error_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= gnt_id_s;
                wr_ptr_r         <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            if (master_readdatavalid && (count_r == {CW{1'b0}})) begin
                rsp_error_r <= 1'b1;
            end
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for avalon_master_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model (granted requester
// as an integer, outstanding reads as a queue of requester IDs).
// -----------------------------------------------------------------------------
module tb_avalon_master_arbiter;

    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int MAXP = 4;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] r0_address, r1_address;
    logic [DW-1:0] r0_writedata, r1_writedata;
    logic          r0_write, r1_write, r0_read, r1_read;
    logic          r0_waitrequest, r1_waitrequest;
    logic [DW-1:0] r0_readdata, r1_readdata;
    logic          r0_readdatavalid, r1_readdatavalid;
    logic [AW-1:0] master_address;
    logic [DW-1:0] master_writedata;
    logic          master_write, master_read;
    logic [DW-1:0] master_readdata;
    logic          master_readdatavalid;
    logic          master_waitrequest;
    logic [2:0]    pending_count;
    logic          rsp_error;

    int  n_checks = 0;
    int  n_errors = 0;

    // Reference model state
    int  m_owner = -1;
    int  m_rr    = 0;
    int  m_q[$];
    bit  m_err   = 1'b0;

    // Requester agents: each holds a queue of commands, head is presented
    op_t ag0[$];
    op_t ag1[$];

    always #5 clk = ~clk;

    avalon_master_arbiter #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_address(r0_address), .r1_address(r1_address),
        .r0_writedata(r0_writedata), .r1_writedata(r1_writedata),
        .r0_write(r0_write), .r1_write(r1_write),
        .r0_read(r0_read), .r1_read(r1_read),
        .r0_waitrequest(r0_waitrequest), .r1_waitrequest(r1_waitrequest),
        .r0_readdata(r0_readdata), .r1_readdata(r1_readdata),
        .r0_readdatavalid(r0_readdatavalid), .r1_readdatavalid(r1_readdatavalid),
        .master_address(master_address), .master_writedata(master_writedata),
        .master_write(master_write), .master_read(master_read),
        .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
        .master_waitrequest(master_waitrequest),
        .pending_count(pending_count), .rsp_error(rsp_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (ag0.size() > 0) begin
            r0_write = ~ag0[0].rd; r0_read = ag0[0].rd;
            r0_address = ag0[0].a; r0_writedata = ag0[0].d;
        end else begin
            r0_write = 1'b0; r0_read = 1'b0;
            r0_address = '0; r0_writedata = '0;
        end
        if (ag1.size() > 0) begin
            r1_write = ~ag1[0].rd; r1_read = ag1[0].rd;
            r1_address = ag1[0].a; r1_writedata = ag1[0].d;
        end else begin
            r1_write = 1'b0; r1_read = 1'b0;
            r1_address = '0; r1_writedata = '0;
        end
    endtask

    task automatic push_op(input int who, input logic rd, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        op_t o;
        o.rd = rd; o.a = a; o.d = d;
        if (who == 0) ag0.push_back(o);
        else ag1.push_back(o);
        drive();
    endtask

    function automatic bit req_wr(input int i);
        return (i == 1) ? r1_write : r0_write;
    endfunction

    function automatic bit req_rd(input int i);
        return (i == 1) ? r1_read : r0_read;
    endfunction

    function automatic bit m_elig(input int i, input int cnt);
        return req_wr(i) || (req_rd(i) && cnt < MAXP);
    endfunction

    // One clock cycle: check outputs against the model, advance model,
    // retire accepted agent commands after the edge.
    task automatic step();
        logic          e_mw, e_mr, e_w0, e_w1, e_v0, e_v1, wv;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        bit            wr, rd, act, acc, push, set_err, p0, p1;
        int            size0, n, cnt_n;
        #1;
        if (!reset_n) begin
            chk("rst_mwrite", 64'(master_write), 64'(0));
            chk("rst_mread", 64'(master_read), 64'(0));
            chk("rst_maddr", 64'(master_address), 64'(0));
            chk("rst_mwdata", 64'(master_writedata), 64'(0));
            chk("rst_r0_wait", 64'(r0_waitrequest), 64'(1));
            chk("rst_r1_wait", 64'(r1_waitrequest), 64'(1));
            chk("rst_r0_rdv", 64'(r0_readdatavalid), 64'(0));
            chk("rst_r1_rdv", 64'(r1_readdatavalid), 64'(0));
            chk("rst_count", 64'(pending_count), 64'(0));
            chk("rst_err", 64'(rsp_error), 64'(0));
            m_owner = -1; m_rr = 0; m_q.delete(); m_err = 1'b0;
        end else begin
            size0 = m_q.size();
            n = m_owner;
            e_mw = 1'b0; e_mr = 1'b0; e_w0 = 1'b1; e_w1 = 1'b1;
            e_a = '0; e_d = '0; wr = 1'b0; rd = 1'b0;
            if (n >= 0) begin
                wr   = req_wr(n);
                rd   = req_rd(n);
                e_a  = (n == 1) ? r1_address : r0_address;
                e_d  = (n == 1) ? r1_writedata : r0_writedata;
                e_mw = wr;
                e_mr = rd && !wr && size0 < MAXP;
                wv   = (rd && !wr && size0 >= MAXP) ? 1'b1 : master_waitrequest;
                if (n == 0) e_w0 = wv;
                else e_w1 = wv;
            end
            act  = e_mw || e_mr;
            acc  = act && !master_waitrequest;
            push = acc && e_mr;
            e_v0 = 1'b0; e_v1 = 1'b0; set_err = 1'b0;
            if (master_readdatavalid) begin
                if (size0 > 0) begin
                    if (m_q[0] == 0) e_v0 = 1'b1;
                    else e_v1 = 1'b1;
                end else begin
                    set_err = 1'b1;
                end
            end
            chk("mwrite", 64'(master_write), 64'(e_mw));
            chk("mread", 64'(master_read), 64'(e_mr));
            chk("maddr", 64'(master_address), 64'(e_a));
            chk("mwdata", 64'(master_writedata), 64'(e_d));
            chk("r0_wait", 64'(r0_waitrequest), 64'(e_w0));
            chk("r1_wait", 64'(r1_waitrequest), 64'(e_w1));
            chk("r0_rdv", 64'(r0_readdatavalid), 64'(e_v0));
            chk("r1_rdv", 64'(r1_readdatavalid), 64'(e_v1));
            chk("r0_rdata", 64'(r0_readdata), 64'(master_readdata));
            chk("r1_rdata", 64'(r1_readdata), 64'(master_readdata));
            chk("count", 64'(pending_count), 64'(size0));
            chk("rsp_err", 64'(rsp_error), 64'(m_err));
            if (e_v0 || e_v1) m_q.delete(0);
            if (set_err) m_err = 1'b1;
            if (push) m_q.push_back(n);
            cnt_n = m_q.size();
            if (n < 0) begin
                if (m_elig(0, size0) && m_elig(1, size0)) m_owner = m_rr;
                else if (m_elig(0, size0)) m_owner = 0;
                else if (m_elig(1, size0)) m_owner = 1;
                else m_owner = -1;
            end else if (acc) begin
                m_rr = 1 - n;
                if (m_elig(1 - n, cnt_n)) m_owner = 1 - n;
                else if (m_elig(n, cnt_n)) m_owner = n;
                else m_owner = -1;
            end else if (!act) begin
                m_owner = -1;
            end
        end
        p0 = reset_n && (r0_write || r0_read) && !r0_waitrequest;
        p1 = reset_n && (r1_write || r1_read) && !r1_waitrequest;
        @(negedge clk);
        if (p0 && ag0.size() > 0) ag0.delete(0);
        if (p1 && ag1.size() > 0) ag1.delete(0);
        drive();
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        reset_n = 1'b0;
        master_readdata = '0; master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
        drive();
        @(negedge clk);
        // Reset with a request already pending: bus must stay quiet
        push_op(0, 1'b0, 26'h2000000, 32'h00FF0000);
        steps(2);

        // T1: single r0 write, one-cycle arbitration
        reset_n = 1'b1;
        #1 chk("t1_arb_mwrite", 64'(master_write), 64'(0));
        step();
        #1 chk("t1_mwrite", 64'(master_write), 64'(1));
        chk("t1_addr", 64'(master_address), 64'(26'h2000000));
        chk("t1_data", 64'(master_writedata), 64'(32'h00FF0000));
        chk("t1_r0_wait", 64'(r0_waitrequest), 64'(0));
        steps(3);
        #1 chk("t1_idle_mwrite", 64'(master_write), 64'(0));
        chk("t1_idle_r0_wait", 64'(r0_waitrequest), 64'(1));

        // T2: both write continuously, no stalls: 8 commands in 1+8 cycles
        for (int i = 0; i < 4; i++) begin
            push_op(0, 1'b0, AW'(26'h10 + i), DW'(32'h100 + i));
            push_op(1, 1'b0, AW'(26'h20 + i), DW'(32'h200 + i));
        end
        steps(9);
        #1 chk("t2_drained", 64'(ag0.size() + ag1.size()), 64'(0));
        steps(3);

        // T3: r1 write stalled 5 cycles, r0 blocked meanwhile
        master_waitrequest = 1'b1;
        push_op(1, 1'b0, 26'h155, 32'hCAFE0001);
        step();
        push_op(0, 1'b0, 26'h0AA, 32'h0000BEEF);
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_hold_mwrite", 64'(master_write), 64'(1));
            chk("t3_hold_addr", 64'(master_address), 64'(26'h155));
            chk("t3_hold_data", 64'(master_writedata), 64'(32'hCAFE0001));
            chk("t3_r0_blocked", 64'(r0_waitrequest), 64'(1));
            step();
        end
        master_waitrequest = 1'b0;
        #1 chk("t3_r1_accept", 64'(r1_waitrequest), 64'(0));
        steps(5);
        #1 chk("t3_drained", 64'(ag0.size() + ag1.size()), 64'(0));

        // T4: fill FIFO with 4 r0 reads, 5th stalls, then 4 returns
        for (int i = 0; i < 5; i++) push_op(0, 1'b1, AW'(26'h100 + i), '0);
        steps(8);
        #1 chk("t4_count_full", 64'(pending_count), 64'(4));
        chk("t4_5th_stalled", 64'(r0_waitrequest), 64'(1));
        chk("t4_no_read", 64'(master_read), 64'(0));
        steps(2);
        #1 chk("t4_5th_left", 64'(ag0.size()), 64'(1));
        ag0.delete();
        drive();
        for (int i = 0; i < 4; i++) begin
            master_readdatavalid = 1'b1;
            master_readdata = DW'(32'hA + i);
            #1 chk("t4_r0_rdv", 64'(r0_readdatavalid), 64'(1));
            chk("t4_r0_rdata", 64'(r0_readdata), 64'(32'hA + i));
            step();
        end
        master_readdatavalid = 1'b0;
        #1 chk("t4_count_zero", 64'(pending_count), 64'(0));
        step();

        // r1 write moves the round-robin pointer back to r0
        push_op(1, 1'b0, 26'h3, 32'h3);
        steps(4);

        // T5: reads r0,r1,r0; first return coincides with third accept
        push_op(0, 1'b1, 26'h300, '0);
        push_op(0, 1'b1, 26'h301, '0);
        push_op(1, 1'b1, 26'h400, '0);
        steps(3);
        master_readdatavalid = 1'b1; master_readdata = 32'h11;
        #1 chk("t5_first_r0", 64'(r0_readdatavalid), 64'(1));
        chk("t5_third_accept", 64'(r0_waitrequest), 64'(0));
        chk("t5_count_before", 64'(pending_count), 64'(2));
        step();
        master_readdata = 32'h22;
        #1 chk("t5_count_same", 64'(pending_count), 64'(2));
        chk("t5_second_r1", 64'(r1_readdatavalid), 64'(1));
        step();
        master_readdata = 32'h33;
        #1 chk("t5_third_r0", 64'(r0_readdatavalid), 64'(1));
        step();
        master_readdatavalid = 1'b0;
        steps(2);

        // T6: beat with empty FIFO sets sticky error until reset
        master_readdatavalid = 1'b1; master_readdata = 32'h55;
        #1 chk("t6_no_r0_rdv", 64'(r0_readdatavalid), 64'(0));
        chk("t6_no_r1_rdv", 64'(r1_readdatavalid), 64'(0));
        step();
        master_readdatavalid = 1'b0;
        steps(3);
        #1 chk("t6_err_sticky", 64'(rsp_error), 64'(1));
        chk("t6_count_zero", 64'(pending_count), 64'(0));
        reset_n = 1'b0;
        #1 chk("t6_err_cleared", 64'(rsp_error), 64'(0));
        step();
        reset_n = 1'b1;

        // Reset mid-flight: in-flight reads forgotten, late beat flags error
        push_op(1, 1'b1, 26'h500, '0);
        push_op(1, 1'b1, 26'h501, '0);
        steps(3);
        #1 chk("t7_count_two", 64'(pending_count), 64'(2));
        reset_n = 1'b0;
        ag1.delete();
        drive();
        step();
        reset_n = 1'b1;
        step();
        master_readdatavalid = 1'b1;
        step();
        master_readdatavalid = 1'b0;
        #1 chk("t7_late_beat_err", 64'(rsp_error), 64'(1));
        step();

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            master_waitrequest   = ($urandom_range(3) == 0);
            master_readdata      = $urandom;
            master_readdatavalid = (m_q.size() > 0) ? ($urandom_range(2) == 0)
                                                    : ($urandom_range(60) == 0);
            if (ag0.size() == 0 && $urandom_range(2) != 0)
                push_op(0, 1'($urandom_range(1)), AW'($urandom), DW'($urandom));
            if (ag1.size() == 0 && $urandom_range(2) != 0)
                push_op(1, 1'($urandom_range(1)), AW'($urandom), DW'($urandom));
            if (c == 400) reset_n = 1'b0;
            if (c == 402) reset_n = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avalon_master_arbiter.md
Name: avalon_master_arbiter

Overview:
Shares the single Avalon-MM bus master port to SDRAM between two requesters: requester 0 is the pixel/fill write engine and requester 1 is the CSR-driven read/write path. The block applies round-robin arbitration per transaction and holds each grant until the fabric accepts the command. It also tracks outstanding reads so that each readdatavalid beat is routed back to the requester that issued the read. It sits between the custom master logic and the PCIe/Qsys fabric master interface.

Parameters:
ADDRESSWIDTH, 26, master/requester address width
DATAWIDTH, 32, data width
MAX_PENDING, 4, maximum outstanding reads in flight (power of 2, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
r0_address, r1_address  in  ADDRESSWIDTH  requester address
r0_writedata, r1_writedata  in  DATAWIDTH  requester write data
r0_write, r1_write  in  1  write request
r0_read, r1_read  in  1  read request
r0_waitrequest, r1_waitrequest  out  1  stall to requester; command accepted on the cycle it is 0 while request is asserted
r0_readdata, r1_readdata  out  DATAWIDTH  master_readdata, broadcast to both
r0_readdatavalid, r1_readdatavalid  out  1  read beat belongs to this requester
master_address  out  ADDRESSWIDTH  to fabric
master_writedata  out  DATAWIDTH  to fabric
master_write, master_read  out  1  to fabric
master_readdata  in  DATAWIDTH  from fabric
master_readdatavalid  in  1  from fabric
master_waitrequest  in  1  from fabric
pending_count  out  log2(MAX_PENDING)+1  outstanding reads
rsp_error  out  1  sticky flag: readdatavalid received with no outstanding read

Behaviour:
- Reset values: state IDLE, rr pointer = 0, pending FIFO empty, pending_count 0, rsp_error 0.
- While in reset: master_write/read 0, master_address/writedata 0, r*_waitrequest 1, r*_readdatavalid 0.
- A requester is requesting when write|read is set. Write has precedence if both are set; that read is ignored.
- A read request is eligible only if pending_count < MAX_PENDING. An ineligible read is held with waitrequest=1.
- FSM states: IDLE, GRANT0, GRANT1. The grant is registered.
- IDLE: if eligible requesters exist, pick one; the rr pointer gives that requester priority. Go to GRANTn on the next cycle. Arbitration latency is 1 cycle.
- GRANTn: drive the master outputs combinationally from requester n. rn_waitrequest = master_waitrequest. The other requester sees waitrequest=1.
- Acceptance in GRANTn = requester n requesting and master_waitrequest=0.
- On acceptance, set rr pointer = other requester. If the other requester is eligible, go to GRANT(other); else if n is still eligible, stay in GRANTn (back-to-back); else go to IDLE.
- If requester n drops its request while waiting (protocol violation), return to IDLE with no bus command issued.
- Outputs when not granted: master_write/read 0, address/writedata 0.
- Read accept pushes requester ID into the pending FIFO (depth MAX_PENDING, wrap-around pointers).
- master_readdatavalid pops the FIFO and asserts rX_readdatavalid for the popped ID in the same cycle (combinational from the FIFO head).
- Push and pop in the same cycle: count is unchanged, and ordering is preserved (FIFO order equals fabric return order).
- readdatavalid with an empty FIFO: no rX_readdatavalid, rsp_error is set (cleared only by reset), count stays 0.
- pending_count is updated +1 on push and -1 on pop, and is never allowed to exceed MAX_PENDING.
- Reset asserted mid-transaction: everything returns to reset values immediately. Reads in flight are forgotten; their late beats set rsp_error.
- Writes never enter the FIFO and have no response phase.

Test Plan:
- Reset then r0 write to 0x2000000 with data 0x00FF0000, waitrequest=0 -> master_write=1 one cycle after request, address 0x2000000, r0_waitrequest=0 same cycle; state returns to IDLE.
- r0 and r1 write continuously, fabric never stalls -> grants alternate 0,1,0,1; each accepted command takes one cycle after the initial 1-cycle arbitration.
- r1 write with master_waitrequest held 1 for 5 cycles -> master_write held with stable address/data, r0 blocked, single acceptance on cycle 6.
- r0 issues 4 reads (MAX_PENDING=4), no returns -> pending_count=4, 5th read stalled. Return 4 beats 0xA,0xB,0xC,0xD -> r0_readdatavalid x4 in order, count back to 0.
- Interleaved reads r0,r1,r0 with the first return coinciding with the third accept -> count stays constant that cycle; readdatavalid routed r0,r1,r0.
- master_readdatavalid pulse with empty FIFO -> no rX_readdatavalid, rsp_error=1 until reset_n low.
